// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Writes the quotient to LO and the remainder to HI through the HI/LO write port.
//
// A divide takes WIDTH iterations, one quotient bit per cycle. The result is
// presented for one END cycle with ready_o=1 and we_o=2'b11.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start_i    divide request; held by the pipeline until ready_o
//   signed_i   1 = DIV (two's complement), 0 = DIVU; sampled with start_i
//   annul_i    cancel the operation in flight
//   opdata1_i  dividend
//   opdata2_i  divisor
//   hi_o       remainder (registered)
//   lo_o       quotient (registered)
//   we_o       HI/LO write enable, 2'b11 only in the result cycle
//   ready_o    result valid pulse (registered)
//   stall_o    pipeline stall request (combinational)
//
// Optional macro DIV_ZERO_FAST_EN: a zero divisor bypasses the iteration and
// produces lo=all-ones, hi=raw dividend two cycles after acceptance.
// -----------------------------------------------------------------------------
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             annul_i,
  input  logic [WIDTH-1:0] opdata1_i,
  input  logic [WIDTH-1:0] opdata2_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [1:0]       we_o,
  output logic             ready_o,
  output logic             stall_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_BUSY    = 2'd2,
    S_END     = 2'd3
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] dvd_q;      // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q;      // divisor magnitude
  logic [WIDTH-1:0] rem_q;      // partial remainder
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [1:0]       we_q;
  logic             ready_q;

  // Operand magnitudes for the signed case.
  logic             sign1;
  logic             sign2;
  logic [WIDTH-1:0] abs1;
  logic [WIDTH-1:0] abs2;

  assign sign1 = signed_i & opdata1_i[WIDTH-1];
  assign sign2 = signed_i & opdata2_i[WIDTH-1];
  assign abs1  = sign1 ? (~opdata1_i + 1'b1) : opdata1_i;
  assign abs2  = sign2 ? (~opdata2_i + 1'b1) : opdata2_i;

  // One restoring step: shift in the next dividend bit, trial subtract.
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             qbit;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  always_comb begin
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    trial   = {rem_q, dvd_q[WIDTH-1]};
    diff    = trial - {1'b0, dvs_q};
    qbit    = ~diff[WIDTH];
    rem_nxt = qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_nxt = {dvd_q[WIDTH-2:0], qbit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath is a handful of flops, not a memory, so it is reset with the FSM.
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      we_q      <= 2'b00;
      ready_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults; a later assignment in the same cycle overrides them.
      we_q    <= 2'b00;
      ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i && !annul_i) begin
`ifdef DIV_ZERO_FAST_EN
            if (opdata2_i == '0) begin
              dvd_q   <= opdata1_i;   // raw dividend, no sign fix-up
              state_q <= S_DIVZERO;
            end else
`endif
            begin
              dvd_q     <= abs1;
              dvs_q     <= abs2;
              rem_q     <= '0;
              cnt_q     <= '0;
              neg_quo_q <= sign1 ^ sign2;
              neg_rem_q <= sign1;
              state_q   <= S_BUSY;
            end
          end
        end

`ifdef DIV_ZERO_FAST_EN
        S_DIVZERO: begin
          if (annul_i) begin
            state_q <= S_IDLE;
          end else begin
            lo_q    <= '1;
            hi_q    <= dvd_q;
            we_q    <= 2'b11;
            ready_q <= 1'b1;
            state_q <= S_END;
          end
        end
`endif

        S_BUSY: begin
          if (annul_i) begin
            state_q <= S_IDLE;
          end else begin
            rem_q <= rem_nxt;
            dvd_q <= quo_nxt;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              // Final step: the fixed-up result is registered so it is valid in END.
              lo_q    <= neg_quo_q ? (~quo_nxt + 1'b1) : quo_nxt;
              hi_q    <= neg_rem_q ? (~rem_nxt + 1'b1) : rem_nxt;
              we_q    <= 2'b11;
              ready_q <= 1'b1;
              state_q <= S_END;
            end
          end
        end

        // END lasts one cycle; the write is already committed, so annul_i is ignored.
        S_END:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stall_o = !rst && ((state_q == S_IDLE && start_i && !annul_i) ||
                            state_q == S_BUSY || state_q == S_DIVZERO);

  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign we_o    = we_q;
  assign ready_o = ready_q;

endmodule
